// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC register, instruction memory and decode for fetch_queue.
// The fetch queue takes the slave view; the surrounding pipeline drives the master view.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_accept;
  logic            flush;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_misaligned;

  modport slave (
    input  pc_in, pc_valid, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    output pc_accept, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_misaligned
  );

  modport master (
    output pc_in, pc_valid, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    input  pc_accept, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_misaligned
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: PC -> imem request -> DEPTH-slot buffer -> decode.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into pre-filled NOP slots flagged if_misaligned.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
`endif

  logic [XLEN-1:0] pc_r    [DEPTH];
  logic [XLEN-1:0] instr_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic [DEPTH-1:0] mis_r;
`endif
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [PW:0]   alloc_cnt_r;
  logic [PW:0]   drop_cnt_r;

  logic [PW+1:0] credit_s;
  logic          open_s;
  logic          mis_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          if_valid_s;
  logic          pop_s;
  logic          fill_s;
  logic          drop_hit_s;
  logic          fill_found_s;
  logic [PW-1:0] fill_idx_s;
  logic [PW-1:0] scan_idx_s;
  logic [PW:0]   unfilled_s;
  logic [PW:0]   drop_flush_s;

  // Oldest allocated-but-unfilled slot, plus how many such slots a flush would orphan
  always_comb begin
    fill_found_s = 1'b0;
    fill_idx_s   = head_r;
    scan_idx_s   = head_r;
    unfilled_s   = (PW+1)'(0);
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_r + PW'(i);
      if (((PW+1)'(i) < alloc_cnt_r) && !filled_r[scan_idx_s]) begin
        unfilled_s = unfilled_s + (PW+1)'(1);
        if (!fill_found_s) begin
          fill_found_s = 1'b1;
          fill_idx_s   = scan_idx_s;
        end else begin
          fill_found_s = 1'b1;
        end
      end else begin
        unfilled_s = unfilled_s;
      end
    end
  end

  // Request, accept, pop, fill and drop decisions for this cycle
  always_comb begin
    credit_s = (PW+2)'(DEPTH) - {1'b0, alloc_cnt_r} - {1'b0, drop_cnt_r};
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_s = (bus.pc_in[1:0] != 2'b00);
`else
    mis_s = 1'b0;
`endif
    open_s      = bus.pc_valid & (credit_s != (PW+2)'(0)) & ~bus.flush & ~rst;
    req_valid_s = open_s & ~mis_s;
    accept_s    = (req_valid_s & bus.imem_req_ready) | (open_s & mis_s);
    if_valid_s  = filled_r[head_r] & ~bus.flush;
    pop_s       = if_valid_s & bus.if_ready;
    drop_hit_s  = bus.imem_resp_valid & (drop_cnt_r != (PW+1)'(0));
    fill_s      = bus.imem_resp_valid & (drop_cnt_r == (PW+1)'(0)) & fill_found_s;
    // A response arriving during the flush retires one of the requests being orphaned
    drop_flush_s = drop_cnt_r + unfilled_s;
    if (bus.imem_resp_valid && (drop_flush_s != (PW+1)'(0))) begin
      drop_flush_s = drop_flush_s - (PW+1)'(1);
    end else begin
      drop_flush_s = drop_flush_s;
    end
  end

  assign bus.pc_accept      = accept_s;
  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.if_valid       = if_valid_s;
  assign bus.if_pc          = pc_r[head_r];
  assign bus.if_instr       = instr_r[head_r];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.if_misaligned  = mis_r[head_r] & filled_r[head_r];
`else
  assign bus.if_misaligned  = 1'b0;
`endif

  // Slot storage, ring pointers and occupancy/drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= PW'(0);
      tail_r      <= PW'(0);
      alloc_cnt_r <= (PW+1)'(0);
      drop_cnt_r  <= (PW+1)'(0);
      filled_r    <= {DEPTH{1'b0}};
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_r       <= {DEPTH{1'b0}};
`endif
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]    <= {XLEN{1'b0}};
        instr_r[i] <= {XLEN{1'b0}};
      end
    end else if (bus.flush) begin
      head_r      <= PW'(0);
      tail_r      <= PW'(0);
      alloc_cnt_r <= (PW+1)'(0);
      drop_cnt_r  <= drop_flush_s;
      filled_r    <= {DEPTH{1'b0}};
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_r       <= {DEPTH{1'b0}};
`endif
    end else begin
      if (accept_s) begin
        pc_r[tail_r]     <= bus.pc_in;
        filled_r[tail_r] <= mis_s;
        tail_r           <= tail_r + PW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_r[tail_r]    <= mis_s;
        if (mis_s) begin
          instr_r[tail_r] <= NOP_INSTR;
        end
`endif
      end
      if (fill_s) begin
        instr_r[fill_idx_s]  <= bus.imem_resp_data;
        filled_r[fill_idx_s] <= 1'b1;
      end
      if (pop_s) begin
        filled_r[head_r] <= 1'b0;
        head_r           <= head_r + PW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_r[head_r]    <= 1'b0;
`endif
      end
      if (drop_hit_s) begin
        drop_cnt_r <= drop_cnt_r - (PW+1)'(1);
      end
      alloc_cnt_r <= alloc_cnt_r + {{PW{1'b0}}, accept_s} - {{PW{1'b0}}, pop_s};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: PC-register model, in-order latency memory model, expected-output queue.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) bus ();
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  mem_t mem_q[$];
  int acc_log[$];
  int pop_log[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int lat = 1;
  int pc_left = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [31:0] pc_reg = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000 ^ {a[7:0], 24'h00_0000};
  endfunction

  task automatic set_pc(input logic [31:0] a, input int n);
    pc_reg = a;
    pc_left = n;
    bus.pc_in = a;
    bus.pc_valid = (n > 0);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    acc_cnt = 0;
    pop_cnt = 0;
  endtask

  // One clock: sample outputs mid-cycle, update models, then drive next-cycle inputs at negedge.
  task automatic cycle();
    exp_t e;
    mem_t m;
    logic mis_v;
    #1;
    if (bus.flush) begin
      nchk++;
      if (bus.pc_accept !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
        nerr++;
        $display("FAIL flush_quiet: accept=%b if_valid=%b req=%b want 0 0 0",
                 bus.pc_accept, bus.if_valid, bus.imem_req_valid);
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      nchk++;
      if (bus.imem_req_addr !== pc_reg) begin
        nerr++;
        $display("FAIL req_addr: got %h want %h", bus.imem_req_addr, pc_reg);
      end
      m.addr = bus.imem_req_addr;
      m.due = cyc + lat;
      mem_q.push_back(m);
    end
    if (bus.pc_accept) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_v = (pc_reg[1:0] != 2'b00);
`else
      mis_v = 1'b0;
`endif
      e.pc = pc_reg;
      e.instr = mis_v ? NOP : mem_word(pc_reg);
      e.mis = mis_v;
      exp_q.push_back(e);
      acc_log.push_back(cyc);
      acc_cnt++;
      pc_reg = pc_reg + 32'd4;
      pc_left--;
    end
    if (bus.if_valid && bus.if_ready) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_out: got pc %h with nothing expected", bus.if_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.if_pc !== e.pc || bus.if_instr !== e.instr || bus.if_misaligned !== e.mis) begin
          nerr++;
          $display("FAIL out_data: got pc %h instr %h mis %b want pc %h instr %h mis %b",
                   bus.if_pc, bus.if_instr, bus.if_misaligned, e.pc, e.instr, e.mis);
        end
      end
      pop_log.push_back(cyc);
      pop_cnt++;
    end
    if (bus.flush) exp_q.delete();
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = mem_word(m.addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = 32'h0;
    end
    bus.pc_valid = (pc_left > 0);
    bus.pc_in = pc_reg;
  endtask

  task automatic run_until_pops(input int want, input int budget, input string name);
    for (int k = 0; k < budget && pop_cnt < want; k++) cycle();
    nchk++;
    if (pop_cnt != want) begin
      nerr++;
      $display("FAIL %s_timeout: got %0d outputs want %0d", name, pop_cnt, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    nchk++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.pc_accept !== 1'b0 ||
        bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || bus.if_misaligned !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: valid=%b req=%b acc=%b pc=%h instr=%h mis=%b want all 0",
               bus.if_valid, bus.imem_req_valid, bus.pc_accept, bus.if_pc, bus.if_instr, bus.if_misaligned);
    end
  endtask

  task automatic test_stream();
    clear_logs();
    lat = 1;
    bus.if_ready = 1'b1;
    set_pc(32'h0, 4);
    run_until_pops(4, 30, "stream");
    if (pop_log.size() == 4 && acc_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (pop_log[k] != acc_log[0] + 2 + k) begin
          nerr++;
          $display("FAIL stream_timing: output %0d at cycle %0d want %0d", k, pop_log[k], acc_log[0] + 2 + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    lat = 1;
    bus.if_ready = 1'b0;
    set_pc(32'h40, 6);
    for (int k = 0; k < 12; k++) cycle();
    #1;
    nchk++;
    if (acc_cnt != 4 || bus.pc_accept !== 1'b0 || bus.pc_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_full: got %0d accepts, accept=%b want 4 accepts, accept=0", acc_cnt, bus.pc_accept);
    end
    bus.if_ready = 1'b1;
    run_until_pops(6, 40, "bp");
    nchk++;
    if (acc_cnt != 6 || acc_log.size() < 5 || pop_log.size() < 1 || acc_log[4] < pop_log[0]) begin
      nerr++;
      $display("FAIL bp_resume: got %0d accepts want 6 with 5th accept no earlier than first output", acc_cnt);
    end
  endtask

  task automatic test_flush_outstanding();
    clear_logs();
    lat = 6;
    bus.if_ready = 1'b1;
    set_pc(32'h200, 3);
    for (int k = 0; k < 3; k++) cycle();
    set_pc(32'h100, 1);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    run_until_pops(1, 40, "flush3");
    for (int k = 0; k < 4; k++) cycle();
    nchk++;
    if (pop_cnt != 1 || exp_q.size() != 0 || mem_q.size() != 0) begin
      nerr++;
      $display("FAIL flush3_drain: got %0d outputs, %0d pending want 1 output, 0 pending", pop_cnt, exp_q.size());
    end
  endtask

  task automatic test_flush_resp();
    clear_logs();
    lat = 3;
    bus.if_ready = 1'b1;
    set_pc(32'h300, 2);
    for (int k = 0; k < 2; k++) cycle();
    for (int k = 0; k < 10 && !bus.imem_resp_valid; k++) cycle();
    nchk++;
    if (bus.imem_resp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL flushresp_setup: got resp_valid=%b want 1", bus.imem_resp_valid);
    end
    set_pc(32'h100, 1);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    run_until_pops(1, 40, "flushresp");
  endtask

  task automatic test_reset_mid();
    clear_logs();
    lat = 1;
    bus.if_ready = 1'b0;
    set_pc(32'h400, 2);
    for (int k = 0; k < 5; k++) cycle();
    pc_left = 0;
    bus.pc_valid = 1'b1;
    bus.pc_in = 32'h500;
    rst = 1'b1;
    #1;
    nchk++;
    if (bus.imem_req_valid !== 1'b0 || bus.pc_accept !== 1'b0) begin
      nerr++;
      $display("FAIL rst_req: req=%b accept=%b want 0 0", bus.imem_req_valid, bus.pc_accept);
    end
    cycle();
    rst = 1'b0;
    #1;
    nchk++;
    if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.if_pc !== 32'h0) begin
      nerr++;
      $display("FAIL rst_mid: valid=%b req=%b pc=%h want 0 0 0", bus.if_valid, bus.imem_req_valid, bus.if_pc);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    set_pc(32'h1000, 20);
    for (int k = 0; k < 400 && pop_cnt < 20; k++) begin
      lat = $urandom_range(1, 3);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.if_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    nchk++;
    if (pop_cnt != 20) begin
      nerr++;
      $display("FAIL b2b_timeout: got %0d outputs want 20", pop_cnt);
    end
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    clear_logs();
    lat = 1;
    bus.if_ready = 1'b0;
    set_pc(32'h0FC, 1);
    for (int k = 0; k < 3; k++) cycle();
    bus.imem_req_ready = 1'b0;
    set_pc(32'h102, 1);
    #1;
    nchk++;
    if (bus.imem_req_valid !== 1'b0 || bus.pc_accept !== 1'b1) begin
      nerr++;
      $display("FAIL mis_accept: req=%b accept=%b want 0 1", bus.imem_req_valid, bus.pc_accept);
    end
    cycle();
    bus.imem_req_ready = 1'b1;
    set_pc(32'h200, 1);
    for (int k = 0; k < 3; k++) cycle();
    bus.if_ready = 1'b1;
    run_until_pops(3, 20, "mis");
  endtask
`endif

  initial begin
    bus.pc_in = 32'h0;
    bus.pc_valid = 1'b0;
    bus.flush = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'h0;
    bus.if_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_outstanding();
    test_flush_resp();
    test_reset_mid();
    test_back_to_back();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
